add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arb_pkg.sv | 6 +
 rtl/add_arbiter_rr.sv | 45 ++++
 rtl/add_arbiter.sv | 59 +++++
 3 files changed

// File: rtl/add_arb_pkg.sv
// add_arb_pkg: shared defaults and FSM state encoding for add_arbiter.
package add_arb_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_W_OP  = 16;
    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/add_arbiter_rr.sv
// rr_arbiter: one-hot grant plus index; round-robin from ptr+1 with ADD_ARB_RR_EN,
// otherwise fixed priority (lowest index wins, ptr ignored).
module rr_arbiter
    import add_arb_pkg::*;
#(
    parameter int N    = DEF_N_REQ,
    parameter int W_ID = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [W_ID-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [W_ID-1:0] idx
);
`ifdef ADD_ARB_RR_EN
    int k;
    // Walk from the farthest candidate to the nearest so the nearest after ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        k     = 0;
        for (int i = N; i >= 1; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = W_ID'(k);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                idx      = W_ID'(i);
            end
        end
    end
`endif
endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: N_REQ requesters share one registered signed adder with a one-deep output slot.
// Define ADD_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int W_OP  = DEF_W_OP,
    localparam int W_SUM = W_OP + 1,
    localparam int W_ID  = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ-1:0][W_OP-1:0] req_a,
    input  logic [N_REQ-1:0][W_OP-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [W_SUM-1:0]           rsp_sum,
    output logic [W_ID-1:0]            rsp_id
);
    state_e           state;
    logic [W_ID-1:0]  ptr;
    logic [W_ID-1:0]  idx;
    logic [N_REQ-1:0] grant;
    logic             slot_free;
    logic             xfer;
    logic [W_SUM-1:0] sum_next;

    rr_arbiter #(.N(N_REQ), .W_ID(W_ID)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );

    assign slot_free = (state == IDLE) || (state == BUSY && rsp_ready);
    // Held low while in reset so nothing is accepted against a slot being cleared.
    assign req_ready = (rst_n && slot_free) ? grant : '0;
    assign xfer      = |req_ready;
    assign sum_next  = {req_a[idx][W_OP-1], req_a[idx]} + {req_b[idx][W_OP-1], req_b[idx]};
    assign rsp_valid = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rsp_sum <= '0;
            rsp_id  <= '0;
            ptr     <= W_ID'(N_REQ - 1);
        end else if (xfer) begin
            state   <= BUSY;
            rsp_sum <= sum_next;
            rsp_id  <= idx;
            ptr     <= idx;
        end else if (rsp_ready) begin
            state   <= IDLE;
        end
    end
endmodule
